// File: rtl/devilstand_pkg.sv
// Shared types and constants for the devilstand sprite path.
package devilstand_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/devilstand_anim_ctr.sv
// Animation frame counter: advances one sprite frame every ANIM_DIV video frames.
module devilstand_anim_ctr #(
    parameter int FRAMES   = 4,
    parameter int ANIM_DIV = 8,
    parameter int FW       = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          advance,
    output logic [FW-1:0] anim_frame
);

    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            anim_frame <= '0;
        end else if (clear) begin
            div_cnt    <= '0;
            anim_frame <= '0;
        end else if (advance) begin
            if (div_cnt == DW'(ANIM_DIV - 1)) begin
                div_cnt    <= '0;
                anim_frame <= (anim_frame == FW'(FRAMES - 1)) ? '0 : anim_frame + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/devilstand_sprite_fetch.sv
// Per-pixel sprite fetch: scan position -> sprite ROM address -> palette index/hit,
// two clocks from draw_x/draw_y to index_out/hit.
module devilstand_sprite_fetch
    import devilstand_pkg::*;
#(
    parameter int SPRITE_W = 64,
    parameter int SPRITE_H = 64,
    parameter int FRAMES   = 4,
    parameter int ANIM_DIV = 8,
    parameter int ADDR_W   = $clog2(FRAMES * SPRITE_W * SPRITE_H)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  coord_t            draw_x,
    input  coord_t            draw_y,
    input  coord_t            sprite_x,
    input  coord_t            sprite_y,
    input  logic              flip,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index_out,
    output logic              hit,
    output logic              valid_out,
    output fetch_state_t      dbg_state
);

    localparam int FW       = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int FRAME_SZ = SPRITE_W * SPRITE_H;

    fetch_state_t      state;
    coord_t            sx, sy;
    logic              flip_s;
    logic [FW-1:0]     anim_frame;
    logic              capture, anim_clear, anim_advance;
    coord_t            dx, dy, col;
    logic              in_box;
    logic [ADDR_W-1:0] addr_next;
    logic              in_box_d1, pv_d1;

    assign dbg_state    = state;
    assign capture      = enable && frame_start && (state == ARMED || state == ACTIVE);
    assign anim_clear   = enable && frame_start && (state == ARMED);
    assign anim_advance = enable && frame_start && (state == ACTIVE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= OFF;
        end else if (!enable) begin
            state <= OFF;
        end else begin
            case (state)
                OFF:     state <= ARMED;
                ARMED:   if (frame_start) state <= ACTIVE;
                ACTIVE:  state <= ACTIVE;
                default: state <= OFF;
            endcase
        end
    end

    // Shadow copies keep the sprite still for a whole frame even if the CPU moves it mid-scan.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx     <= '0;
            sy     <= '0;
            flip_s <= 1'b0;
        end else if (capture) begin
            sx     <= sprite_x;
            sy     <= sprite_y;
            flip_s <= flip;
        end
    end

    devilstand_anim_ctr #(
        .FRAMES   (FRAMES),
        .ANIM_DIV (ANIM_DIV),
        .FW       (FW)
    ) u_anim_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (anim_clear),
        .advance    (anim_advance),
        .anim_frame (anim_frame)
    );

    // Unsigned wrap makes pixels left of / above the sprite look huge, so one compare suffices.
    always_comb begin
        dx        = draw_x - sx;
        dy        = draw_y - sy;
        col       = flip_s ? coord_t'(SPRITE_W - 1) - dx : dx;
        in_box    = (32'(dx) < 32'(SPRITE_W)) && (32'(dy) < 32'(SPRITE_H))
                    && pix_valid && (state == ACTIVE);
        addr_next = ADDR_W'(anim_frame) * ADDR_W'(FRAME_SZ)
                  + ADDR_W'(dy) * ADDR_W'(SPRITE_W)
                  + ADDR_W'(col);
    end

    // rom_data is expected valid in the cycle after each rom_addr update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            in_box_d1 <= 1'b0;
            pv_d1     <= 1'b0;
            index_out <= TRANSPARENT_IDX;
            hit       <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            if (in_box)
                rom_addr <= addr_next;
            in_box_d1 <= in_box && enable;
            pv_d1     <= pix_valid;
            index_out <= (in_box_d1 && enable) ? rom_data : TRANSPARENT_IDX;
            hit       <= in_box_d1 && enable && (rom_data != TRANSPARENT_IDX);
            valid_out <= pv_d1;
        end
    end

endmodule

// File: tb/tb_devilstand_sprite_fetch.sv
// Directed plus randomized bench for devilstand_sprite_fetch with a behavioural sprite model.
module tb_devilstand_sprite_fetch;
    import devilstand_pkg::*;

    localparam int SW = 64;
    localparam int SH = 64;
    localparam int NF = 4;
    localparam int AD = 8;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n, enable, frame_start, pix_valid, flip;
    coord_t        draw_x, draw_y, sprite_x, sprite_y;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_data, index_out;
    logic          hit, valid_out;
    fetch_state_t  dbg_state;

    logic [3:0] mem [0:(1<<AW)-1];
    assign rom_data = mem[rom_addr];

    always #5 clk = ~clk;

    devilstand_sprite_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .flip        (flip),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .index_out   (index_out),
        .hit         (hit),
        .valid_out   (valid_out),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    fetch_state_t m_state;
    int           m_sx, m_sy, m_fs, m_last_addr;
    bit           m_flip;
    logic [5:0]   exp_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int m_anim();
        return (m_fs / AD) % NF;
    endfunction

    function automatic bit m_inbox(int x, int y, bit pv);
        int dx = x - m_sx;
        int dy = y - m_sy;
        return pv && (m_state == ACTIVE) && dx >= 0 && dx < SW && dy >= 0 && dy < SH;
    endfunction

    function automatic int m_addr(int x, int y);
        int dx = x - m_sx;
        int dy = y - m_sy;
        return (m_anim() * SW * SH + dy * SW + (m_flip ? SW - 1 - dx : dx)) % (1 << AW);
    endfunction

    task automatic m_reset();
        m_state = OFF; m_sx = 0; m_sy = 0; m_flip = 0; m_fs = 0; m_last_addr = 0;
    endtask

    // Model reaction to a frame_start sampled with enable high.
    task automatic m_frame_event();
        if (m_state == ARMED) begin
            m_state = ACTIVE;
            m_fs = 0;
        end else if (m_state == ACTIVE) begin
            m_fs++;
        end
        if (m_state == ACTIVE) begin
            m_sx = int'(sprite_x); m_sy = int'(sprite_y); m_flip = flip;
        end
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        m_frame_event();
    endtask

    task automatic set_enable(bit v);
        enable = v;
        step();
        if (!v) m_state = OFF;
        else if (m_state == OFF) m_state = ARMED;
    endtask

    // One isolated pixel: check rom_addr after 1 clk and the outputs after 2 clk.
    task automatic pixel(string tag, int x, int y, bit pv, bit fs);
        bit       inb = m_inbox(x, y, pv);
        int       a   = inb ? m_addr(x, y) : m_last_addr;
        logic [3:0] idx = inb ? mem[a] : 4'h0;
        draw_x = coord_t'(x); draw_y = coord_t'(y); pix_valid = pv; frame_start = fs;
        step();
        pix_valid = 1'b0; frame_start = 1'b0;
        if (fs) m_frame_event();
        m_last_addr = a;
        check({tag, ".rom_addr"}, 32'(rom_addr), 32'(a));
        step();
        check({tag, ".index"}, 32'(index_out), 32'(idx));
        check({tag, ".hit"}, 32'(hit), 32'(inb && idx != 4'h0));
        check({tag, ".valid"}, 32'(valid_out), 32'(pv));
    endtask

    // Back-to-back random pixels around the sprite, scored through an expected queue.
    task automatic burst(int n);
        logic [5:0] e;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                int x = m_sx - 8 + int'($urandom_range(0, SW + 15));
                int y = m_sy - 8 + int'($urandom_range(0, SH + 15));
                bit pv = ($urandom_range(0, 7) != 0);
                bit inb;
                logic [3:0] idx;
                if (x > 639) x = 639;
                if (y > 479) y = 479;
                inb = m_inbox(x, y, pv);
                if (inb) m_last_addr = m_addr(x, y);
                idx = inb ? mem[m_last_addr] : 4'h0;
                exp_q.push_back({pv, inb && idx != 4'h0, idx});
                draw_x = coord_t'(x); draw_y = coord_t'(y); pix_valid = pv;
            end else begin
                pix_valid = 1'b0;
            end
            step();
            if (i < n) check("burst.rom_addr", 32'(rom_addr), 32'(m_last_addr));
            if (i >= 1) begin
                e = exp_q.pop_front();
                check("burst.index", 32'(index_out), 32'(e[3:0]));
                check("burst.hit", 32'(hit), 32'(e[4]));
                check("burst.valid", 32'(valid_out), 32'(e[5]));
            end
        end
    endtask

    initial begin
        int a;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 4'($urandom_range(0, 15));
        reset_n = 1'b0; enable = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; flip = 1'b0;
        draw_x = '0; draw_y = '0; sprite_x = '0; sprite_y = '0;
        m_reset();
        step(); step();
        check("reset.rom_addr", 32'(rom_addr), 32'd0);
        check("reset.index", 32'(index_out), 32'd0);
        check("reset.hit", 32'(hit), 32'd0);
        check("reset.valid", 32'(valid_out), 32'd0);
        check("reset.state", 32'(dbg_state), 32'(OFF));
        reset_n = 1'b1;
        step();

        // Arm without frame_start: stays ARMED and never hits
        sprite_x = 10'd100; sprite_y = 10'd50; flip = 1'b0;
        set_enable(1'b1);
        step(); step();
        check("armed.state", 32'(dbg_state), 32'(m_state));
        pixel("armed_px", 100, 50, 1'b1, 1'b0);
        check("armed.state2", 32'(dbg_state), 32'(ARMED));

        frame_pulse();
        check("active.state", 32'(dbg_state), 32'(ACTIVE));
        mem[0] = 4'h3;
        pixel("origin_opaque", 100, 50, 1'b1, 1'b0);
        mem[0] = 4'h0;
        pixel("origin_transparent", 100, 50, 1'b1, 1'b0);
        mem[0] = 4'h9;

        // Mirrored sprite and horizontal edges
        flip = 1'b1;
        frame_pulse();
        pixel("flip_row1", 100, 51, 1'b1, 1'b0);
        check("flip_row1.const", 32'(rom_addr), 32'd127);
        pixel("flip_right_edge", 163, 50, 1'b1, 1'b0);
        check("flip_right_edge.const", 32'(rom_addr), 32'd0);
        pixel("flip_past_right", 164, 50, 1'b1, 1'b0);
        pixel("flip_left_of", 99, 50, 1'b1, 1'b0);
        burst(40);

        // Animation: 8th pulse in ACTIVE advances to frame 1, 32nd wraps to 0
        flip = 1'b0;
        repeat (7) frame_pulse();
        pixel("anim_frame1", 100, 50, 1'b1, 1'b0);
        check("anim_frame1.const", 32'(rom_addr), 32'd4096);
        burst(30);
        repeat (24) frame_pulse();
        pixel("anim_wrap", 100, 50, 1'b1, 1'b0);
        check("anim_wrap.const", 32'(rom_addr), 32'd0);

        // Position change only takes effect at frame_start
        sprite_x = 10'd200;
        pixel("move_old_pos", 100, 50, 1'b1, 1'b0);
        pixel("move_new_early", 200, 50, 1'b1, 1'b0);
        frame_pulse();
        pixel("move_new_pos", 200, 50, 1'b1, 1'b0);
        check("move_new_pos.const", 32'(rom_addr), 32'd0);

        // frame_start together with a pixel: pixel uses the old shadow values
        sprite_x = 10'd300;
        pixel("fs_with_pixel", 200, 50, 1'b1, 1'b1);
        pixel("fs_after_new", 300, 50, 1'b1, 1'b0);
        pixel("fs_after_old", 200, 50, 1'b1, 1'b0);
        burst(30);

        // Partially off-screen sprite: no wrap onto column 0
        sprite_x = 10'd600;
        frame_pulse();
        pixel("offscreen_right", 639, 50, 1'b1, 1'b0);
        pixel("offscreen_nowrap", 0, 50, 1'b1, 1'b0);

        // enable falls while a pixel is in flight
        a = m_addr(605, 55);
        mem[a] = 4'h7;
        draw_x = 10'd605; draw_y = 10'd55; pix_valid = 1'b1;
        step();
        m_last_addr = a;
        check("disable.rom_addr", 32'(rom_addr), 32'(a));
        pix_valid = 1'b0; enable = 1'b0;
        step();
        m_state = OFF;
        check("disable.hit", 32'(hit), 32'd0);
        check("disable.index", 32'(index_out), 32'd0);
        check("disable.valid", 32'(valid_out), 32'd1);
        check("disable.state", 32'(dbg_state), 32'(OFF));
        set_enable(1'b1);
        pixel("rearm_no_hit", 605, 55, 1'b1, 1'b0);
        frame_pulse();
        pixel("rearm_hit", 605, 55, 1'b1, 1'b0);

        // Asynchronous reset mid-line while in the box
        a = m_addr(610, 60);
        mem[a] = 4'h5;
        draw_x = 10'd610; draw_y = 10'd60; pix_valid = 1'b1;
        step(); step();
        check("pre_reset.hit", 32'(hit), 32'd1);
        check("pre_reset.index", 32'(index_out), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset.hit", 32'(hit), 32'd0);
        check("async_reset.valid", 32'(valid_out), 32'd0);
        check("async_reset.index", 32'(index_out), 32'd0);
        check("async_reset.rom_addr", 32'(rom_addr), 32'd0);
        m_reset();
        pix_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        m_state = ARMED;
        check("post_reset.state", 32'(dbg_state), 32'(ARMED));
        pixel("post_reset_no_hit", 610, 60, 1'b1, 1'b0);
        frame_pulse();
        pixel("post_reset_rearm", 610, 60, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
